// File: rtl/hex_disp_pkg.sv
// Shared constants for the seven-segment digit counters: per-digit radix limits,
// FSM state encoding and the supported digit count.
package hex_disp_pkg;

  localparam logic [3:0] RADIX_HEX  = 4'hF;
  localparam logic [3:0] RADIX_BCD  = 4'h9;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  function automatic logic [3:0] digit_max(input bit bcd);
    return bcd ? RADIX_BCD : RADIX_HEX;
  endfunction

endpackage

// File: rtl/hex_digit_cell.sv
// One 4-bit counter digit: clear/load/step with wrap at the radix boundary and a
// boundary flag that feeds the carry/borrow chain of the next digit up.
module hex_digit_cell
  import hex_disp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up_dn,
  input  logic [3:0] max,
  input  logic       load,
  input  logic [3:0] load_d,
  input  logic       clear,
  output logic [3:0] q,
  output logic       at_bound
);

  logic [3:0] r_q;
  logic [3:0] w_q_next;

  // A digit above max (only reachable by loading BCD) behaves as a boundary going up,
  // so it wraps to 0 and carries instead of sticking at an illegal code.
  assign at_bound = up_dn ? (r_q >= max) : (r_q == 4'd0);
  assign q        = r_q;

  always_comb begin
    w_q_next = r_q;
    if (clear) begin
      w_q_next = 4'd0;
    end else if (load) begin
      w_q_next = load_d;
    end else if (step) begin
      if (up_dn) begin
        w_q_next = (r_q >= max) ? 4'd0 : r_q + 4'd1;
      end else if ((r_q == 4'd0) || (r_q > max)) begin
        w_q_next = max;
      end else begin
        w_q_next = r_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= 4'd0;
    end else begin
      r_q <= w_q_next;
    end
  end

endmodule

// File: rtl/hex_digit_counter.sv
// Multi-digit hex/BCD up/down counter for a seven-segment bank: prescaler-driven
// count ticks, run/stop FSM, clear/load, single-cycle ripple and rollover pulse.
module hex_digit_counter
  import hex_disp_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 6,
  parameter int BCD     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  tick,
  output logic                  wrap,
  output logic                  running
);

  localparam int              PERIOD    = CLK_HZ / TICK_HZ;
  localparam int              PW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]   PRESC_TC  = PW'(PERIOD - 1);
  localparam logic [3:0]      DIGIT_MAX = digit_max(BCD != 0);

  state_t        r_state;
  logic          r_running;
  logic          r_tick;
  logic          r_wrap;
  logic [PW-1:0] r_presc;

  logic              w_step_en;
  logic [DIGITS:0]   w_carry;
  logic [DIGITS-1:0] w_bound;

  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign running = r_running;

  // A registered tick turns into a step one cycle later unless clear/load take the cycle.
  assign w_step_en  = r_tick & ~clear & ~load;
  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      hex_digit_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .step     (w_step_en & w_carry[gi]),
        .up_dn    (up_dn),
        .max      (DIGIT_MAX),
        .load     (load),
        .load_d   (load_value[4*gi +: 4]),
        .clear    (clear),
        .q        (digits[4*gi +: 4]),
        .at_bound (w_bound[gi])
      );
      assign w_carry[gi+1] = w_carry[gi] & w_bound[gi];
    end
  endgenerate

  // Run/stop FSM together with the prescaler; the prescaler only advances while
  // RUNNING so a pause keeps the partial period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STOPPED;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_STOPPED: begin
          if (run) begin
            r_state   <= ST_RUNNING;
            r_running <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (!run) begin
            r_state   <= ST_STOPPED;
            r_running <= 1'b0;
          end
        end
      endcase
      if (clear || load) begin
        r_presc <= '0;
      end else if (r_state == ST_RUNNING) begin
        if (r_presc == PRESC_TC) begin
          r_presc <= '0;
          r_tick  <= 1'b1;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  // Every digit at its boundary during a step means the whole counter rolls over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step_en & w_carry[DIGITS];
    end
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench: a hex and a BCD counter share one stimulus set; one task per scenario.
module tb_hex_digit_counter;

  localparam int CLK_HZ  = 8;
  localparam int TICK_HZ = 1;
  localparam int DIGITS  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       up_dn = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  logic [7:0] digits_h, digits_b;
  logic       tick_h, tick_b, wrap_h, wrap_b, running_h, running_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hex_digit_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS), .BCD(0)) u_hex (
    .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear), .load(load),
    .load_value(load_value), .digits(digits_h), .tick(tick_h), .wrap(wrap_h),
    .running(running_h)
  );

  hex_digit_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS), .BCD(1)) u_bcd (
    .clk(clk), .reset(reset), .run(run), .up_dn(up_dn), .clear(clear), .load(load),
    .load_value(load_value), .digits(digits_b), .tick(tick_b), .wrap(wrap_b),
    .running(running_b)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load_value = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  // Stops in the cycle where tick is high; n = clocks waited.
  task automatic wait_tick(output int n);
    n = 0;
    while (!tick_h && n < 40) begin
      cyc(1);
      n++;
    end
    n_cmp++;
    if (tick_h !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_tick: tick=%b after %0d clocks, required 1", tick_h, n);
    end
  endtask

  task automatic do_step;
    int n;
    wait_tick(n);
    cyc(1);
  endtask

  task automatic test_reset;
    int n;
    #1 reset = 1'b1;
    cyc(2);
    n_cmp++;
    if ({digits_h, running_h, tick_h, wrap_h} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_state: digits=%h run=%b tick=%b wrap=%b, required 00/0/0/0",
               digits_h, running_h, tick_h, wrap_h);
    end
    reset = 1'b0;
    run = 1'b1;
    do_load(8'h37);
    cyc(3);
    n_cmp++;
    if (digits_h !== 8'h37 || running_h !== 1'b1) begin
      n_bad++;
      $display("FAIL load_37: digits=%h running=%b, required 37/1", digits_h, running_h);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (digits_h !== 8'h00 || digits_b !== 8'h00 || running_h !== 1'b0 || tick_h !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: digits=%h/%h running=%b tick=%b, required 00/00/0/0",
               digits_h, digits_b, running_h, tick_h);
    end
    cyc(2);
    reset = 1'b0;
    wait_tick(n);
    n_cmp++;
    if (n !== 9 || digits_h !== 8'h00) begin
      n_bad++;
      $display("FAIL first_tick: clocks=%0d digits=%h, required 9/00", n, digits_h);
    end
    cyc(1);
    n_cmp++;
    if (digits_h !== 8'h01) begin
      n_bad++;
      $display("FAIL first_step: digits=%h, required 01", digits_h);
    end
  endtask

  task automatic test_hex_up;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    n_cmp++;
    if (digits_h !== 8'h00) begin
      n_bad++;
      $display("FAIL clear: digits=%h, required 00", digits_h);
    end
    for (int i = 1; i <= 16; i++) begin
      do_step();
      n_cmp++;
      if (digits_h !== 8'(i) || wrap_h !== 1'b0) begin
        n_bad++;
        $display("FAIL hex_up_%0d: digits=%h wrap=%b, required %h/0", i, digits_h, wrap_h, 8'(i));
      end
    end
    do_load(8'hFF);
    do_step();
    n_cmp++;
    if (digits_h !== 8'h00 || wrap_h !== 1'b1) begin
      n_bad++;
      $display("FAIL hex_wrap: digits=%h wrap=%b, required 00/1", digits_h, wrap_h);
    end
    cyc(1);
    n_cmp++;
    if (digits_h !== 8'h00 || wrap_h !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_pulse: digits=%h wrap=%b, required 00/0", digits_h, wrap_h);
    end
  endtask

  task automatic test_bcd;
    up_dn = 1'b0;
    do_load(8'h00);
    do_step();
    n_cmp++;
    if (digits_b !== 8'h99 || wrap_b !== 1'b1) begin
      n_bad++;
      $display("FAIL bcd_down_wrap: digits=%h wrap=%b, required 99/1", digits_b, wrap_b);
    end
    n_cmp++;
    if (digits_h !== 8'hFF || wrap_h !== 1'b1) begin
      n_bad++;
      $display("FAIL hex_down_wrap: digits=%h wrap=%b, required FF/1", digits_h, wrap_h);
    end
    cyc(1);
    n_cmp++;
    if (wrap_b !== 1'b0) begin
      n_bad++;
      $display("FAIL bcd_wrap_pulse: wrap=%b, required 0", wrap_b);
    end
    up_dn = 1'b1;
    do_load(8'h0C);
    do_step();
    n_cmp++;
    if (digits_b !== 8'h10 || wrap_b !== 1'b0) begin
      n_bad++;
      $display("FAIL bcd_illegal_up: digits=%h wrap=%b, required 10/0", digits_b, wrap_b);
    end
    n_cmp++;
    if (digits_h !== 8'h0D) begin
      n_bad++;
      $display("FAIL hex_0c_up: digits=%h, required 0D", digits_h);
    end
  endtask

  task automatic test_pause;
    int n;
    int bad;
    do_load(8'h20);
    wait_tick(n);
    cyc(5);
    n_cmp++;
    if (digits_h !== 8'h21) begin
      n_bad++;
      $display("FAIL pre_pause: digits=%h, required 21", digits_h);
    end
    run = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tick_h !== 1'b0 || digits_h !== 8'h21) bad++;
    end
    n_cmp++;
    if (bad != 0 || running_h !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_hold: bad_cycles=%0d running=%b digits=%h, required 0/0/21",
               bad, running_h, digits_h);
    end
    run = 1'b1;
    wait_tick(n);
    n_cmp++;
    if (n !== 3) begin
      n_bad++;
      $display("FAIL resume_tick: clocks=%0d, required 3", n);
    end
    cyc(1);
    n_cmp++;
    if (digits_h !== 8'h22) begin
      n_bad++;
      $display("FAIL resume_step: digits=%h, required 22", digits_h);
    end
  endtask

  task automatic test_clear_load;
    int n;
    do_load(8'hFF);
    wait_tick(n);
    clear = 1'b1;
    load = 1'b1;
    load_value = 8'h42;
    cyc(1);
    clear = 1'b0;
    load = 1'b0;
    n_cmp++;
    if (digits_h !== 8'h00 || wrap_h !== 1'b0 || running_h !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_load_tick: digits=%h wrap=%b running=%b, required 00/0/1",
               digits_h, wrap_h, running_h);
    end
    cyc(1);
    n_cmp++;
    if (digits_h !== 8'h00 || wrap_h !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_no_step: digits=%h wrap=%b, required 00/0", digits_h, wrap_h);
    end
    do_load(8'hFF);
    wait_tick(n);
    do_load(8'h42);
    n_cmp++;
    if (digits_h !== 8'h42 || wrap_h !== 1'b0) begin
      n_bad++;
      $display("FAIL load_tick: digits=%h wrap=%b, required 42/0", digits_h, wrap_h);
    end
  endtask

  task automatic test_back_to_back;
    do_load(8'h10);
    do_step();
    n_cmp++;
    if (digits_h !== 8'h11 || digits_b !== 8'h11) begin
      n_bad++;
      $display("FAIL updn_1: digits=%h/%h, required 11/11", digits_h, digits_b);
    end
    cyc(2);
    up_dn = 1'b0;
    cyc(2);
    up_dn = 1'b1;
    do_step();
    n_cmp++;
    if (digits_h !== 8'h12 || digits_b !== 8'h12) begin
      n_bad++;
      $display("FAIL updn_2: digits=%h/%h, required 12/12", digits_h, digits_b);
    end
    up_dn = 1'b0;
    do_step();
    n_cmp++;
    if (digits_h !== 8'h11 || digits_b !== 8'h11) begin
      n_bad++;
      $display("FAIL updn_3: digits=%h/%h, required 11/11", digits_h, digits_b);
    end
  endtask

  initial begin
    test_reset();
    test_hex_up();
    test_bcd();
    test_pause();
    test_clear_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
